// File: rtl/mmio_switch_port.sv
// Switch input port on the data-memory read path: synchronizer, debouncer,
// and an event FIFO that the processor drains with loads.
module mmio_switch_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned BASE_ADDR       = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic [31:0] address,
  input  logic        rd_strobe,
  output logic        io_hit,
  output logic [31:0] q_io
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_FW-1:0] FIFO_MAX = CNT_FW'(DEPTH);
  localparam logic [31:0]       BASE     = 32'(BASE_ADDR);

  logic [15:0]       sync1_q, sync2_q, cand_q, stable_q;
  logic [15:0]       cand_d, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       q_io_q, q_io_d;

  logic [31:0] offset;
  logic [31:0] rdata;
  logic        rd_hit, push, push_ok, pop, drop, ovf_clr, empty, full;

  always_comb begin
    offset   = address - BASE;
    io_hit   = (offset[31:2] == 30'd0);
    rd_hit   = rd_strobe & io_hit;
    empty    = (count_q == '0);
    full     = (count_q == FIFO_MAX);

    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    // cnt parks at its maximum once a candidate has been steady long enough
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      if (cand_q != stable_q) begin
        stable_d = cand_q;
        push     = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    rdata   = 32'd0;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    case (offset[1:0])
      2'd0: rdata = {16'd0, stable_q};
      2'd2: begin
        if (!empty) rdata = {1'b1, 15'd0, mem_q[rd_ptr_q]};
        pop = rd_hit & ~empty;
      end
      2'd3: begin
        rdata   = 32'(count_q) | {23'd0, ovf_q, 8'd0};
        ovf_clr = rd_hit;
      end
      default: rdata = 32'd0;
    endcase
    q_io_d = rd_hit ? rdata : q_io_q;

    // a pop on the same edge frees the slot a full-FIFO push needs
    push_ok  = push & (~full | pop);
    drop     = push & full & ~pop;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      q_io_q   <= '0;
    end else begin
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      q_io_q   <= q_io_d;
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= stable_d;
  end

  assign q_io = q_io_q;

endmodule

// File: tb/tb_mmio_switch_port.sv
// Bench for mmio_switch_port: directed scenarios plus random switch/read
// traffic, all compared against a queue-based reference model.
module tb_mmio_switch_port;

  localparam int          D     = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'd4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = '0;
  logic [31:0] address = '0;
  logic        rd_strobe = 1'b0;
  logic        io_hit;
  logic [31:0] q_io;

  mmio_switch_port #(
    .DEBOUNCE_CYCLES(D),
    .DEPTH(DEPTH),
    .BASE_ADDR(4096)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw(sw),
    .address(address),
    .rd_strobe(rd_strobe),
    .io_hit(io_hit),
    .q_io(q_io)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: sample history, run length of the synchronized value,
  // and the event FIFO as a queue.
  logic [15:0] samp[$] = '{16'h0, 16'h0};
  int          run = 1;
  logic [15:0] run_val = '0;
  logic [15:0] m_stable = '0;
  logic [15:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_q_io = '0;

  task automatic model_step();
    logic [31:0] off;
    logic [15:0] v;
    logic [31:0] data;
    bit pop, clr, push, drop;
    int sz;
    if (reset) begin
      samp = '{16'h0, 16'h0};
      run = 1; run_val = '0; m_stable = '0;
      m_q.delete(); m_ovf = 1'b0; m_q_io = '0;
    end else begin
      off = address - BASE;
      pop = 0; clr = 0; push = 0; drop = 0;
      if (rd_strobe && off < 32'd4) begin
        data = 32'd0;
        case (off)
          32'd0: data = {16'h0, m_stable};
          32'd2: if (m_q.size() > 0) begin
            data = {16'h8000, m_q[0]};
            pop = 1;
          end
          32'd3: begin
            data = 32'(m_q.size()) | (m_ovf ? 32'h100 : 32'h0);
            clr = 1;
          end
          default: data = 32'd0;
        endcase
        m_q_io = data;
      end
      // a value must be the synchronized output on D+1 consecutive edges
      v = samp[1];
      if (v == run_val) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
        run_val = v;
      end
      if (run >= D + 1 && v != m_stable) begin
        m_stable = v;
        push = 1;
      end
      sz = m_q.size();
      if (pop) m_q.delete(0);
      if (push) begin
        if (sz < DEPTH || pop) m_q.push_back(v);
        else drop = 1;
      end
      m_ovf = (m_ovf && !clr) || drop;
      samp.push_front(sw);
      samp.delete(2);
    end
  endtask

  task automatic cyc(input logic rs, input logic [15:0] s, input logic [31:0] a, input logic st);
    reset = rs; sw = s; address = a; rd_strobe = st;
    #1;
    check("io_hit", 32'(io_hit), ((a - BASE) < 32'd4) ? 32'd1 : 32'd0);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("q_io", q_io, m_q_io);
  endtask

  task automatic idle(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) cyc(1'b0, s, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] off, input logic [15:0] s);
    cyc(1'b0, s, BASE + off, 1'b1);
  endtask

  task automatic rst(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) cyc(1'b1, s, 32'd0, 1'b0);
  endtask

  initial begin
    logic [15:0] cur;
    logic [31:0] a;
    int hold;

    // power-up with switches on
    rst(2, 16'hA5A5);
    check("rst_q_io", q_io, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      rd(0, 16'hA5A5);
      if (k == 7) check("stable_pre", q_io, 32'd0);
      if (k == 8) check("stable_a5", q_io, 32'h0000A5A5);
    end
    rd(3, 16'hA5A5); check("status_one", q_io, 32'h1);
    rd(2, 16'hA5A5); check("event_a5", q_io, 32'h8000A5A5);
    rd(2, 16'hA5A5); check("event_empty", q_io, 32'h0);

    // short glitch must not change stable
    rst(2, 16'h0001);
    idle(8, 16'h0001);
    rd(2, 16'h0001); check("event_1", q_io, 32'h80000001);
    idle(3, 16'h0003);
    idle(10, 16'h0001);
    rd(0, 16'h0001); check("glitch_stable", q_io, 32'h1);
    rd(3, 16'h0001); check("glitch_status", q_io, 32'h0);

    // overflow: five changes into four entries
    rst(2, 16'h0);
    for (int v = 1; v <= 5; v++) idle(8, 16'(v));
    rd(3, 16'h5); check("ovf_status", q_io, 32'h104);
    for (int v = 1; v <= 4; v++) begin
      rd(2, 16'h5); check("ovf_event", q_io, 32'h80000000 | 32'(v));
    end
    rd(2, 16'h5); check("ovf_empty", q_io, 32'h0);
    rd(3, 16'h5); check("ovf_cleared", q_io, 32'h0);

    // push and pop on the same edge while full
    rst(2, 16'h0);
    for (int v = 1; v <= 4; v++) idle(8, 16'(v));
    idle(6, 16'h9);
    rd(2, 16'h9); check("full_pop", q_io, 32'h80000001);
    rd(3, 16'h9); check("full_status", q_io, 32'h4);
    rd(2, 16'h9); check("full_ev2", q_io, 32'h80000002);
    rd(2, 16'h9); check("full_ev3", q_io, 32'h80000003);
    rd(2, 16'h9); check("full_ev4", q_io, 32'h80000004);
    rd(2, 16'h9); check("full_ev9", q_io, 32'h80000009);

    // reset mid-operation with events queued
    rst(2, 16'h0);
    for (int v = 1; v <= 3; v++) idle(8, 16'(v));
    rd(3, 16'h3); check("pre_rst_status", q_io, 32'h3);
    rst(1, 16'h3);
    check("mid_rst_q_io", q_io, 32'h0);
    rd(3, 16'h3); check("post_rst_status", q_io, 32'h0);

    // strobe outside the port's window
    idle(10, 16'h3);
    rd(3, 16'h3); check("redebounce_status", q_io, 32'h1);
    cyc(1'b0, 16'h3, 32'd12, 1'b1);
    check("addr12_io_hit", 32'(io_hit), 32'd0);
    check("addr12_q_io", q_io, 32'h1);
    rd(3, 16'h3); check("addr12_count", q_io, 32'h1);

    // random traffic
    rst(2, 16'h0);
    cur = 16'h0;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 3) != 0) cur = 16'($urandom_range(0, 15));
        hold = $urandom_range(1, 12);
      end
      hold--;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = BASE + 32'($urandom_range(0, 3));
        4: a = BASE - 32'd1;
        5: a = BASE + 32'd4;
        6: a = 32'd12;
        default: a = $urandom;
      endcase
      cyc($urandom_range(0, 499) == 0, cur, a, $urandom_range(0, 9) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
